apb_master_if: RTL and testbench

- APB initiator (requester) that turns single-beat requests from an internal module into APB3/APB4 transfers (SETUP then ACCESS phase).
- Returns read data, slave error and timeout status to the requester.
- Counterpart of the team's apb_slave_if; sits between a local controller and the APB fabric / decoder.
- One outstanding transfer at a time.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_timeout_cnt.sv | 41 ++++
 rtl/apb_master_if.sv | 158 +++++++++++++++
 tb/tb_apb_master_if.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions for the master and slave interface blocks.
package apb_pkg;

  // Bus-phase state encoding used by both APB endpoints.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  // PPROT bit positions.
  localparam int unsigned APB_PROT_PRIV_BIT  = 0;
  localparam int unsigned APB_PROT_NS_BIT    = 1;
  localparam int unsigned APB_PROT_INSTR_BIT = 2;

  // Number of byte lanes for a given data width.
  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter; flags the last permitted wait cycle.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLE = 16
) (
  input  logic apb_clk_in,
  input  logic apb_rstn_in,
  input  logic clear_in,
  input  logic enable_in,
  output logic expired_out
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLE > 0) ? $clog2(TIMEOUT_CYCLE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  // Count wait cycles; clear has priority, never wrap past all-ones.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      r_cnt <= '0;
    end else if (clear_in) begin
      r_cnt <= '0;
    end else if (enable_in && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYCLE == 0) begin : g_no_timeout
      // Timeout disabled: keep the counter observable but never expire.
      logic w_unused;
      assign w_unused    = ^r_cnt;
      assign expired_out = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLE - 1);
      // High during the final wait cycle before the transfer is abandoned.
      assign expired_out = (r_cnt == CNT_LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_master_if.sv
// APB3/APB4 initiator: one outstanding single-beat transfer, with timeout.
module apb_master_if
  import apb_pkg::*;
#(
  parameter  int unsigned APB_DATA_WIDTH = 32,
  parameter  int unsigned APB_ADDR_WIDTH = 32,
  parameter  int unsigned TIMEOUT_CYCLE  = 16,
  localparam int unsigned STRB_WIDTH     = strb_width(APB_DATA_WIDTH)
) (
  input  logic                      apb_clk_in,
  input  logic                      apb_rstn_in,
  // Requester side
  input  logic                      req_valid_in,
  output logic                      req_ready_out,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_in,
  input  logic                      req_write_in,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_in,
  input  logic [STRB_WIDTH-1:0]     req_strb_in,
  input  logic [2:0]                req_prot_in,
  output logic                      rsp_valid_out,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_out,
  output logic                      rsp_error_out,
  output logic                      rsp_timeout_out,
  // APB side
  output logic [APB_ADDR_WIDTH-1:0] apb_addr_out,
  output logic                      apb_psel_out,
  output logic                      apb_penable_out,
  output logic                      apb_write_out,
  output logic [APB_DATA_WIDTH-1:0] apb_wdata_out,
  output logic [STRB_WIDTH-1:0]     apb_strb_out,
  output logic [2:0]                apb_prot_out,
  input  logic                      apb_ready_in,
  input  logic [APB_DATA_WIDTH-1:0] apb_rdata_in,
  input  logic                      apb_slverr_in
);

  apb_state_e                r_state;
  logic                      r_out_of_rst;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_write;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0]     r_strb;
  logic [2:0]                r_prot;
  logic                      r_rsp_valid;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_error;
  logic                      r_rsp_timeout;

  logic w_cnt_clear;
  logic w_cnt_enable;
  logic w_expired;
  logic w_accept;

  // Stays low while reset is held so ready only rises after the first edge out of reset.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      r_out_of_rst <= 1'b0;
    end else begin
      r_out_of_rst <= 1'b1;
    end
  end

  assign req_ready_out = (r_state == StIdle) && r_out_of_rst;
  assign w_accept      = req_valid_in && req_ready_out;

  assign w_cnt_clear  = (r_state == StSetup);
  assign w_cnt_enable = (r_state == StAccess) && !apb_ready_in;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLE (TIMEOUT_CYCLE)
  ) u_timeout_cnt (
    .apb_clk_in  (apb_clk_in),
    .apb_rstn_in (apb_rstn_in),
    .clear_in    (w_cnt_clear),
    .enable_in   (w_cnt_enable),
    .expired_out (w_expired)
  );

  // Transfer FSM with all bus and response outputs registered.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      r_state       <= StIdle;
      r_addr        <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_write       <= 1'b0;
      r_wdata       <= '0;
      r_strb        <= '0;
      r_prot        <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (w_accept) begin
            r_addr  <= req_addr_in;
            r_write <= req_write_in;
            r_prot  <= req_prot_in;
            // Reads present no write data and no active byte lanes.
            r_wdata <= req_write_in ? req_wdata_in : '0;
            r_strb  <= req_write_in ? req_strb_in : '0;
            r_psel  <= 1'b1;
            r_state <= StSetup;
          end
        end
        StSetup: begin
          r_penable <= 1'b1;
          r_state   <= StAccess;
        end
        StAccess: begin
          // PREADY on the last counted cycle wins over the timeout.
          if (apb_ready_in) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= (!r_write && !apb_slverr_in) ? apb_rdata_in : '0;
            r_rsp_error   <= apb_slverr_in;
            r_rsp_timeout <= 1'b0;
            r_state       <= StIdle;
          end else if (w_expired) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= StIdle;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign apb_addr_out    = r_addr;
  assign apb_psel_out    = r_psel;
  assign apb_penable_out = r_penable;
  assign apb_write_out   = r_write;
  assign apb_wdata_out   = r_wdata;
  assign apb_strb_out    = r_strb;
  assign apb_prot_out    = r_prot;
  assign rsp_valid_out   = r_rsp_valid;
  assign rsp_rdata_out   = r_rsp_rdata;
  assign rsp_error_out   = r_rsp_error;
  assign rsp_timeout_out = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_if.sv
// Directed self-checking bench for apb_master_if (TIMEOUT_CYCLE = 4).
module tb_apb_master_if;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  apb_master_if #(
    .APB_DATA_WIDTH (32),
    .APB_ADDR_WIDTH (32),
    .TIMEOUT_CYCLE  (4)
  ) dut (
    .apb_clk_in      (clk),
    .apb_rstn_in     (rstn),
    .req_valid_in    (req_valid),
    .req_ready_out   (req_ready),
    .req_addr_in     (req_addr),
    .req_write_in    (req_write),
    .req_wdata_in    (req_wdata),
    .req_strb_in     (req_strb),
    .req_prot_in     (req_prot),
    .rsp_valid_out   (rsp_valid),
    .rsp_rdata_out   (rsp_rdata),
    .rsp_error_out   (rsp_error),
    .rsp_timeout_out (rsp_timeout),
    .apb_addr_out    (paddr),
    .apb_psel_out    (psel),
    .apb_penable_out (penable),
    .apb_write_out   (pwrite),
    .apb_wdata_out   (pwdata),
    .apb_strb_out    (pstrb),
    .apb_prot_out    (pprot),
    .apb_ready_in    (pready),
    .apb_rdata_in    (prdata),
    .apb_slverr_in   (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input string tag, input logic exp_psel, input logic exp_pen);
    chk({tag, ".psel"}, 64'(psel), 64'(exp_psel));
    chk({tag, ".penable"}, 64'(penable), 64'(exp_pen));
  endtask

  task automatic rsp(input string tag, input logic v, input logic [31:0] d, input logic e,
                     input logic t);
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(v));
    chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(d));
    chk({tag, ".rsp_error"}, 64'(rsp_error), 64'(e));
    chk({tag, ".rsp_timeout"}, 64'(rsp_timeout), 64'(t));
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_strb  = s;
    req_prot  = p;
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;

    // ---- Reset state ----
    tick();
    chk("rst.ready", 64'(req_ready), 64'd0);
    bus("rst", 1'b0, 1'b0);
    rsp("rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst.paddr", 64'(paddr), 64'd0);
    #3 rstn = 1'b1;
    tick();
    tick();
    chk("rel.ready", 64'(req_ready), 64'd1);

    // ---- Read, zero wait ----
    issue(32'h0000_1000, 1'b0, 32'hAAAA_AAAA, 4'hF, 3'b000);
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0;
    bus("rd.setup", 1'b1, 1'b0);
    chk("rd.setup.ready", 64'(req_ready), 64'd0);
    chk("rd.paddr", 64'(paddr), 64'h1000);
    chk("rd.pwrite", 64'(pwrite), 64'd0);
    chk("rd.pstrb", 64'(pstrb), 64'd0);
    chk("rd.pwdata", 64'(pwdata), 64'd0);
    tick();
    bus("rd.access", 1'b1, 1'b1);
    chk("rd.access.valid", 64'(rsp_valid), 64'd0);
    tick();
    bus("rd.done", 1'b0, 1'b0);
    rsp("rd.done", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("rd.done.ready", 64'(req_ready), 64'd1);
    tick();
    rsp("rd.after", 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // ---- Write, 3 wait states ----
    issue(32'h0000_0024, 1'b1, 32'h1234_5678, 4'b0011, 3'b010);
    pready = 1'b0;
    prdata = 32'h5555_5555;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    req_strb  = 4'h0;
    req_prot  = 3'b111;
    bus("wr.setup", 1'b1, 1'b0);
    chk("wr.pwrite", 64'(pwrite), 64'd1);
    chk("wr.pwdata", 64'(pwdata), 64'h1234_5678);
    chk("wr.pstrb", 64'(pstrb), 64'h3);
    chk("wr.pprot", 64'(pprot), 64'h2);
    tick();
    bus("wr.acc1", 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus("wr.wait", 1'b1, 1'b1);
      chk("wr.wait.paddr", 64'(paddr), 64'h24);
      chk("wr.wait.pwdata", 64'(pwdata), 64'h1234_5678);
      chk("wr.wait.valid", 64'(rsp_valid), 64'd0);
    end
    pready = 1'b1;
    tick();
    bus("wr.done", 1'b0, 1'b0);
    rsp("wr.done", 1'b1, 32'h0, 1'b0, 1'b0);
    chk("wr.hold.paddr", 64'(paddr), 64'h24);

    // ---- Slave error ----
    issue(32'h0000_0008, 1'b0, 32'h0, 4'h0, 3'b000);
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'h0000_FFFF;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    bus("err.done", 1'b0, 1'b0);
    rsp("err.done", 1'b1, 32'h0, 1'b1, 1'b0);
    pslverr = 1'b0;

    // ---- Timeout: PREADY held low ----
    issue(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b001);
    pready = 1'b0;
    prdata = 32'h1111_2222;
    tick();
    req_valid = 1'b0;
    tick();
    bus("to.acc1", 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus("to.wait", 1'b1, 1'b1);
      chk("to.wait.valid", 64'(rsp_valid), 64'd0);
    end
    tick();
    bus("to.done", 1'b0, 1'b0);
    rsp("to.done", 1'b1, 32'h0, 1'b1, 1'b1);
    tick();
    rsp("to.after", 1'b0, 32'h0, 1'b1, 1'b1);

    // ---- PREADY on the 4th ACCESS cycle beats the timeout ----
    issue(32'h0000_0044, 1'b0, 32'h0, 4'h0, 3'b000);
    pready = 1'b0;
    prdata = 32'h0BAD_F00D;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    bus("late.acc4", 1'b1, 1'b1);
    pready = 1'b1;
    tick();
    bus("late.done", 1'b0, 1'b0);
    rsp("late.done", 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);

    // ---- Back-to-back: valid held high for 3 requests ----
    b2b_addr[0] = 32'h0000_0100;
    b2b_addr[1] = 32'h0000_0200;
    b2b_addr[2] = 32'h0000_0300;
    b2b_data[0] = 32'hA0A0_0001;
    b2b_data[1] = 32'hB0B0_0002;
    b2b_data[2] = 32'hC0C0_0003;
    pready = 1'b1;
    issue(b2b_addr[0], 1'b0, 32'h0, 4'h0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus("b2b.setup", 1'b1, 1'b0);
      chk("b2b.setup.paddr", 64'(paddr), 64'(b2b_addr[i]));
      chk("b2b.setup.valid", 64'(rsp_valid), 64'd0);
      if (i < 2) req_addr = b2b_addr[i+1];
      else req_valid = 1'b0;
      prdata = b2b_data[i];
      tick();
      bus("b2b.access", 1'b1, 1'b1);
      chk("b2b.access.paddr", 64'(paddr), 64'(b2b_addr[i]));
      tick();
      bus("b2b.gap", 1'b0, 1'b0);
      rsp("b2b.done", 1'b1, b2b_data[i], 1'b0, 1'b0);
    end
    tick();
    bus("b2b.end", 1'b0, 1'b0);
    chk("b2b.end.valid", 64'(rsp_valid), 64'd0);

    // ---- Reset during an ACCESS wait state ----
    issue(32'h0000_0500, 1'b0, 32'h0, 4'h0, 3'b100);
    pready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    bus("mid.wait", 1'b1, 1'b1);
    #2 rstn = 1'b0;
    #1;
    bus("mid.rst", 1'b0, 1'b0);
    rsp("mid.rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid.rst.ready", 64'(req_ready), 64'd0);
    chk("mid.rst.paddr", 64'(paddr), 64'd0);
    chk("mid.rst.pprot", 64'(pprot), 64'd0);
    pready = 1'b1;
    tick();
    chk("mid.rst.valid", 64'(rsp_valid), 64'd0);
    #3 rstn = 1'b1;
    tick();
    chk("mid.rel.valid", 64'(rsp_valid), 64'd0);
    tick();
    chk("mid.rel.ready", 64'(req_ready), 64'd1);
    issue(32'h0000_0600, 1'b0, 32'h0, 4'h0, 3'b000);
    prdata = 32'h55AA_55AA;
    tick();
    req_valid = 1'b0;
    bus("post.setup", 1'b1, 1'b0);
    chk("post.paddr", 64'(paddr), 64'h600);
    tick();
    bus("post.access", 1'b1, 1'b1);
    tick();
    bus("post.done", 1'b0, 1'b0);
    rsp("post.done", 1'b1, 32'h55AA_55AA, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
